// File: rtl/training_sample_feeder.sv
// Dataset buffer and sequencer feeding (x1, x2, t) samples to the perceptron over a four-phase handshake.
// Optional epoch limit (DONE state, exhausted flag) is enabled by defining FEEDER_EPOCH_LIMIT_EN.
module training_sample_feeder #(
  parameter int DEPTH      = 64,
  parameter int AW         = 6,
  parameter int MAX_EPOCHS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        wrEn,
  input  logic [6:0]  wrX1,
  input  logic [6:0]  wrX2,
  input  logic [1:0]  wrT,
  input  logic        loadDone,
  input  logic        requestFlag,
  output logic [31:0] nOutput,
  output logic [6:0]  x1Output,
  output logic [6:0]  x2Output,
  output logic [1:0]  tOutput,
  output logic        dataReady,
  output logic        full,
  output logic        empty,
  output logic        epochEnd,
  output logic [15:0] epochCount,
  output logic        exhausted
);

  typedef enum logic [2:0] {
    LOAD,
    SERVE,
    FETCH,
    READY
`ifdef FEEDER_EPOCH_LIMIT_EN
    , DONE
`endif
  } state_t;

  if ((1 << AW) < DEPTH || MAX_EPOCHS < 1) begin : g_bad_params
    $error("training_sample_feeder: AW too small for DEPTH or MAX_EPOCHS < 1");
  end

  state_t state, next_state;

  logic [15:0]   mem [DEPTH];
  logic [15:0]   ram_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [15:0]   epoch_next;
  logic          write_ok, load_go, read_go, release_go, last_sample;

  assign write_ok    = (state == LOAD) && wrEn && !full;
  // A write in the same cycle as loadDone counts toward the non-empty check.
  assign load_go     = (state == LOAD) && loadDone && ((count != '0) || write_ok);
  assign read_go     = (state == SERVE) && requestFlag;
  assign release_go  = (state == READY) && !requestFlag;
  assign last_sample = ({1'b0, rd_ptr} == (count - 1'b1));
  assign epoch_next  = (epochCount == 16'hFFFF) ? epochCount : epochCount + 16'd1;

  assign nOutput = 32'(count);
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);

`ifdef FEEDER_EPOCH_LIMIT_EN
  logic limit_hit;
  assign limit_hit = release_go && last_sample && (32'(epoch_next) >= MAX_EPOCHS);
`else
  assign exhausted = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = LOAD;
    end else begin
      case (state)
        LOAD:  if (load_go) next_state = SERVE;
        SERVE: if (requestFlag) next_state = FETCH;
        FETCH: next_state = READY;
        READY: begin
          if (!requestFlag) begin
`ifdef FEEDER_EPOCH_LIMIT_EN
            next_state = limit_hit ? DONE : SERVE;
`else
            next_state = SERVE;
`endif
          end
        end
`ifdef FEEDER_EPOCH_LIMIT_EN
        DONE:  next_state = DONE;
`endif
        default: next_state = LOAD;
      endcase
    end
  end

  // Sample RAM: never reset, contents survive clear.
  always_ff @(posedge clk) begin
    if (write_ok && !clear) mem[wr_ptr] <= {wrX1, wrX2, wrT};
    if (read_go && !clear)  ram_q <= mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      x1Output   <= '0;
      x2Output   <= '0;
      tOutput    <= '0;
      dataReady  <= 1'b0;
      epochEnd   <= 1'b0;
      epochCount <= '0;
`ifdef FEEDER_EPOCH_LIMIT_EN
      exhausted  <= 1'b0;
`endif
    end else begin
      epochEnd <= 1'b0;
      if (clear) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        dataReady  <= 1'b0;
        epochCount <= '0;
`ifdef FEEDER_EPOCH_LIMIT_EN
        exhausted  <= 1'b0;
`endif
      end else begin
        if (write_ok) begin
          wr_ptr <= wr_ptr + 1'b1;
          count  <= count + 1'b1;
        end
        if (load_go) rd_ptr <= '0;
        if (state == FETCH) begin
          x1Output  <= ram_q[15:9];
          x2Output  <= ram_q[8:2];
          tOutput   <= ram_q[1:0];
          dataReady <= 1'b1;
        end
        // Releasing the last sample of a pass wraps to sample 0 and closes the epoch.
        if (release_go) begin
          dataReady <= 1'b0;
          if (last_sample) begin
            rd_ptr     <= '0;
            epochEnd   <= 1'b1;
            epochCount <= epoch_next;
          end else begin
            rd_ptr <= rd_ptr + 1'b1;
          end
        end
`ifdef FEEDER_EPOCH_LIMIT_EN
        if (limit_hit) exhausted <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_training_sample_feeder.sv
// Directed bench for training_sample_feeder: a model of the buffer pushes expected samples to a
// scoreboard queue at each request and pops them when dataReady rises.
module tb_training_sample_feeder;
  localparam int DEPTH      = 64;
  localparam int AW         = 6;
  localparam int MAX_EPOCHS = 2;

  logic        clk, rst, clear, wrEn, loadDone, requestFlag;
  logic [6:0]  wrX1, wrX2;
  logic [1:0]  wrT;
  logic [31:0] nOutput;
  logic [6:0]  x1Output, x2Output;
  logic [1:0]  tOutput;
  logic        dataReady, full, empty, epochEnd, exhausted;
  logic [15:0] epochCount;

  int testCount = 0;
  int failCount = 0;

  logic [15:0] modelMem [DEPTH];
  logic [15:0] expQ [$];
  int modelCount, modelRd, modelEpoch;
  bit modelLoad, modelExh;

  training_sample_feeder #(.DEPTH(DEPTH), .AW(AW), .MAX_EPOCHS(MAX_EPOCHS)) dut (
    .clk(clk), .rst(rst), .clear(clear), .wrEn(wrEn), .wrX1(wrX1), .wrX2(wrX2), .wrT(wrT),
    .loadDone(loadDone), .requestFlag(requestFlag), .nOutput(nOutput), .x1Output(x1Output),
    .x2Output(x2Output), .tOutput(tOutput), .dataReady(dataReady), .full(full), .empty(empty),
    .epochEnd(epochEnd), .epochCount(epochCount), .exhausted(exhausted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    modelLoad = 1; modelCount = 0; modelRd = 0; modelEpoch = 0; modelExh = 0;
    expQ.delete();
  endtask

  // Drives one load-port cycle and mirrors its effect in the model.
  task automatic applyStimulus(input logic we, input logic [6:0] x1, input logic [6:0] x2,
                               input logic [1:0] t, input logic ld);
    wrEn = we; wrX1 = x1; wrX2 = x2; wrT = t; loadDone = ld;
    if (modelLoad) begin
      if (we && modelCount < DEPTH) begin
        modelMem[modelCount] = {x1, x2, t};
        modelCount++;
      end
      if (ld && modelCount > 0) begin
        modelLoad = 0;
        modelRd   = 0;
      end
    end
    tick();
    wrEn = 0; loadDone = 0;
  endtask

  task automatic doClear();
    clear = 1;
    tick();
    clear = 0;
    resetModel();
    checkOutput("clear dataReady", dataReady, 0);
    checkOutput("clear epochCount", epochCount, 0);
    checkOutput("clear nOutput", nOutput, 0);
    checkOutput("clear empty", empty, 1);
  endtask

  task automatic handshake(input string tag);
    logic [15:0] exp;
    bit lastS;
    expQ.push_back(modelMem[modelRd]);
    requestFlag = 1;
    tick();
    checkOutput({tag, " early"}, dataReady, 0);
    tick();
    checkOutput({tag, " ready"}, dataReady, 1);
    exp = expQ.pop_front();
    checkOutput({tag, " data"}, {x1Output, x2Output, tOutput}, exp);
    requestFlag = 0;
    tick();
    lastS = (modelRd == modelCount - 1);
    modelRd = lastS ? 0 : modelRd + 1;
    if (lastS && modelEpoch < 65535) modelEpoch++;
`ifdef FEEDER_EPOCH_LIMIT_EN
    if (lastS && modelEpoch >= MAX_EPOCHS) modelExh = 1;
`endif
    checkOutput({tag, " release"}, dataReady, 0);
    checkOutput({tag, " epochEnd"}, epochEnd, lastS);
    checkOutput({tag, " epochCount"}, epochCount, modelEpoch);
    checkOutput({tag, " exhausted"}, exhausted, modelExh);
  endtask

  initial begin
    clk = 0; rst = 0; clear = 0; wrEn = 0; loadDone = 0; requestFlag = 0;
    wrX1 = 0; wrX2 = 0; wrT = 0;
    resetModel();
    repeat (2) @(negedge clk);
    checkOutput("rst dataReady", dataReady, 0);
    checkOutput("rst epochEnd", epochEnd, 0);
    checkOutput("rst exhausted", exhausted, 0);
    checkOutput("rst full", full, 0);
    checkOutput("rst empty", empty, 1);
    checkOutput("rst nOutput", nOutput, 0);
    checkOutput("rst epochCount", epochCount, 0);
    checkOutput("rst data", {x1Output, x2Output, tOutput}, 0);
    rst = 1;
    tick();

    applyStimulus(1, 7'd5, 7'd9, 2'd1, 0);
    applyStimulus(1, 7'd120, 7'd3, 2'd2, 0);
    applyStimulus(1, 7'd0, 7'd127, 2'd0, 0);
    applyStimulus(0, 7'd0, 7'd0, 2'd0, 1);
    checkOutput("load3 nOutput", nOutput, 3);
    checkOutput("load3 empty", empty, 0);
    checkOutput("load3 full", full, 0);
    for (int i = 0; i < 4; i++) handshake($sformatf("hs%0d", i));

    applyStimulus(1, 7'd1, 7'd1, 2'd1, 0);
    checkOutput("serve wrEn ignored", nOutput, 3);

    requestFlag = 1;
    tick(); tick();
    checkOutput("midserve ready", dataReady, 1);
    checkOutput("midserve data", {x1Output, x2Output, tOutput}, modelMem[modelRd]);
    doClear();
    requestFlag = 0;
    tick();

    applyStimulus(0, 7'd0, 7'd0, 2'd0, 1);
    requestFlag = 1;
    tick(); tick(); tick();
    checkOutput("empty loadDone stays", dataReady, 0);
    checkOutput("empty loadDone nOutput", nOutput, 0);
    requestFlag = 0;
    tick();

    applyStimulus(1, 7'd33, 7'd44, 2'd3, 1);
    checkOutput("wr+ld nOutput", nOutput, 1);
    checkOutput("wr+ld empty", empty, 0);
    handshake("single");

    doClear();
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1, 7'(i), 7'(i * 3 + 1), 2'(i), 0);
    checkOutput("fill full", full, 1);
    checkOutput("fill nOutput", nOutput, DEPTH);
    checkOutput("fill empty", empty, 0);
    applyStimulus(0, 7'd0, 7'd0, 2'd0, 1);
    for (int i = 0; i < DEPTH; i++) handshake($sformatf("full%0d", i));

    requestFlag = 1;
    tick(); tick();
    checkOutput("prereset ready", dataReady, 1);
    #2 rst = 0;
    #1;
    checkOutput("async dataReady", dataReady, 0);
    checkOutput("async nOutput", nOutput, 0);
    checkOutput("async empty", empty, 1);
    checkOutput("async full", full, 0);
    checkOutput("async epochCount", epochCount, 0);
    checkOutput("async data", {x1Output, x2Output, tOutput}, 0);
    checkOutput("async exhausted", exhausted, 0);
    requestFlag = 0;
    @(negedge clk);
    rst = 1;
    resetModel();
    tick();

    applyStimulus(1, 7'd11, 7'd22, 2'd1, 0);
    applyStimulus(1, 7'd99, 7'd88, 2'd2, 1);
    checkOutput("pair nOutput", nOutput, 2);
    for (int i = 0; i < 4; i++) handshake($sformatf("pair%0d", i));
`ifdef FEEDER_EPOCH_LIMIT_EN
    requestFlag = 1;
    tick(); tick(); tick();
    checkOutput("done no ready", dataReady, 0);
    checkOutput("done exhausted", exhausted, 1);
    requestFlag = 0;
    tick();
`else
    handshake("pair4");
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
